reg_count_ctrl: RTL and testbench

REG_COUNT_CTRL -- requirements
Module: reg_count_ctrl

---
 rtl/reg_pkg.sv | 16 +
 rtl/reg_count_ctrl_if.sv | 26 ++
 rtl/sat_sub.sv | 12 +
 rtl/reg_count_ctrl.sv | 108 ++++++++++
 tb/tb_reg_count_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the register-file countdown controller:
// FSM state encoding and default datapath widths.
package reg_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CHECK,
      S_WRITE,
      S_DONE
   } state_t;

endpackage

// File: rtl/reg_count_ctrl_if.sv
// Register-file port bundle: two read ports (data returned on negedge) and
// one write port committed on posedge.
interface reg_count_ctrl_if #(
   parameter int DATA_W = reg_pkg::DATA_W_DEF,
   parameter int ADDR_W = reg_pkg::ADDR_W_DEF
);

   logic [ADDR_W-1:0] A1;
   logic [ADDR_W-1:0] A2;
   logic [ADDR_W-1:0] A3;
   logic [DATA_W-1:0] WD3;
   logic              regWrite;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;

   modport master (
      output A1, A2, A3, WD3, regWrite,
      input  RD1, RD2
   );

   modport slave (
      input  A1, A2, A3, WD3, regWrite,
      output RD1, RD2
   );

endinterface

// File: rtl/sat_sub.sv
// Unsigned subtract that clamps at zero instead of wrapping.
module sat_sub #(
   parameter int DATA_W = reg_pkg::DATA_W_DEF
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   assign y = (a < b) ? '0 : a - b;

endmodule

// File: rtl/reg_count_ctrl.sv
// Countdown controller: repeatedly writes R[cnt] <= sat(R[cnt] - R[step])
// until R[cnt] reaches zero, flagging a zero step or an iteration cap as error.
module reg_count_ctrl
   import reg_pkg::*;
#(
   parameter int          DATA_W   = DATA_W_DEF,
   parameter int          ADDR_W   = ADDR_W_DEF,
   parameter int unsigned MAX_ITER = 32'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] cnt_addr,
   input  logic [ADDR_W-1:0] step_addr,
   reg_count_ctrl_if.master  rf,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] iter_count
);

   localparam logic [DATA_W-1:0] MAX_ITER_W = DATA_W'(MAX_ITER);

   state_t            state, state_d;
   logic [ADDR_W-1:0] cnt_a_q, cnt_a_d;
   logic [ADDR_W-1:0] step_a_q, step_a_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [DATA_W-1:0] iter_q, iter_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] diff;
   logic              in_loop;

   sat_sub #(.DATA_W(DATA_W)) u_sat_sub (
      .a (rf.RD1),
      .b (rf.RD2),
      .y (diff)
   );

   always_comb begin
      state_d  = state;
      cnt_a_d  = cnt_a_q;
      step_a_d = step_a_q;
      wd_d     = wd_q;
      iter_d   = iter_q;
      err_d    = err_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               cnt_a_d  = cnt_addr;
               step_a_d = step_addr;
               err_d    = 1'b0;
               iter_d   = '0;
               state_d  = S_READ;
            end
         end
         S_READ:  state_d = S_CHECK;
         S_CHECK: begin
            // Termination has priority over the error conditions.
            if (rf.RD1 == '0) begin
               state_d = S_DONE;
            end else if (rf.RD2 == '0 || iter_q == MAX_ITER_W) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wd_d    = diff;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            iter_d  = iter_q + DATA_W'(1);
            state_d = S_READ;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt_a_q  <= '0;
         step_a_q <= '0;
         wd_q     <= '0;
         iter_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_d;
         cnt_a_q  <= cnt_a_d;
         step_a_q <= step_a_d;
         wd_q     <= wd_d;
         iter_q   <= iter_d;
         err_q    <= err_d;
      end
   end

   // Bus outputs are gated by state so they read zero outside an active run.
   assign in_loop     = (state == S_READ) || (state == S_CHECK) || (state == S_WRITE);
   assign rf.A1       = in_loop ? cnt_a_q : '0;
   assign rf.A2       = in_loop ? step_a_q : '0;
   assign rf.A3       = (state == S_WRITE) ? cnt_a_q : '0;
   assign rf.WD3      = (state == S_WRITE) ? wd_q : '0;
   assign rf.regWrite = (state == S_WRITE);
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);
   assign err         = err_q;
   assign iter_count  = iter_q;

endmodule

// File: tb/tb_reg_count_ctrl.sv
// Bench for reg_count_ctrl: register-file model, countdown reference model,
// directed cases, mid-run reset and randomized runs on two cap settings.
module tb_reg_count_ctrl;

   localparam int DW = 16;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          start0 = 1'b0, start1 = 1'b0;
   logic [AW-1:0] ca0 = '0, sa0 = '0, ca1 = '0, sa1 = '0;
   logic          busy0, done0, err0, busy1, done1, err1;
   logic [DW-1:0] iter0, iter1;

   reg_count_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) rf0 ();
   reg_count_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) rf1 ();

   reg_count_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .cnt_addr(ca0), .step_addr(sa0),
      .rf(rf0), .busy(busy0), .done(done0), .err(err0), .iter_count(iter0)
   );

   reg_count_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAX_ITER(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .cnt_addr(ca1), .step_addr(sa1),
      .rf(rf1), .busy(busy1), .done(done1), .err(err1), .iter_count(iter1)
   );

   // Register files: read data registered on negedge, writes on posedge.
   logic [DW-1:0] regs0 [16];
   logic [DW-1:0] regs1 [16];
   logic          pl_en0 = 1'b0, pl_en1 = 1'b0;
   logic [AW-1:0] pl_a = '0;
   logic [DW-1:0] pl_d = '0;
   int            wq0[$], wq1[$];

   always @(posedge clk) begin
      if (rf0.regWrite) regs0[rf0.A3] <= rf0.WD3;
      if (pl_en0) regs0[pl_a] <= pl_d;
      if (rf1.regWrite) regs1[rf1.A3] <= rf1.WD3;
      if (pl_en1) regs1[pl_a] <= pl_d;
   end

   always @(negedge clk) begin
      rf0.RD1 <= regs0[rf0.A1];
      rf0.RD2 <= regs0[rf0.A2];
      rf1.RD1 <= regs1[rf1.A1];
      rf1.RD2 <= regs1[rf1.A2];
      if (rf0.regWrite) wq0.push_back(int'(rf0.A3) * 65536 + int'(rf0.WD3));
      if (rf1.regWrite) wq1.push_back(int'(rf1.A3) * 65536 + int'(rf1.WD3));
   end

   // Observation mux selecting the instance under test.
   bit            cur = 1'b0;
   logic          m_busy, m_done, m_err, m_rw;
   logic [DW-1:0] m_iter, m_wd;
   logic [AW-1:0] m_a1, m_a2, m_a3;
   assign m_busy = cur ? busy1 : busy0;
   assign m_done = cur ? done1 : done0;
   assign m_err  = cur ? err1 : err0;
   assign m_rw   = cur ? rf1.regWrite : rf0.regWrite;
   assign m_iter = cur ? iter1 : iter0;
   assign m_wd   = cur ? rf1.WD3 : rf0.WD3;
   assign m_a1   = cur ? rf1.A1 : rf0.A1;
   assign m_a2   = cur ? rf1.A2 : rf0.A2;
   assign m_a3   = cur ? rf1.A3 : rf0.A3;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Reference: iterate the countdown rules on plain integers.
   task automatic model(input int rc, input int rs, input bit same, input int maxi,
                        output int n, output bit e);
      int v, s, w;
      exp_q.delete();
      v = rc;
      s = same ? rc : rs;
      n = 0;
      e = 1'b0;
      while (1) begin
         if (v == 0) break;
         if (s == 0 || n == maxi) begin
            e = 1'b1;
            break;
         end
         w = (v > s) ? v - s : 0;
         exp_q.push_back(w);
         v = w;
         if (same) s = w;
         n++;
      end
   endtask

   task automatic drive_start(input bit v, input int c, input int s);
      if (cur) begin start1 = v; ca1 = AW'(c); sa1 = AW'(s); end
      else     begin start0 = v; ca0 = AW'(c); sa0 = AW'(s); end
   endtask

   task automatic preload(input int a, input int d);
      @(negedge clk);
      pl_a = AW'(a);
      pl_d = DW'(d);
      if (cur) pl_en1 = 1'b1; else pl_en0 = 1'b1;
      @(negedge clk);
      pl_en0 = 1'b0;
      pl_en1 = 1'b0;
   endtask

   task automatic run_case(input string tag, input bit sel, input int c, input int st,
                           input int rc, input int rs, input int maxi, input bit dbl);
      int  n, base, cyc, got_n;
      bit  e;
      cur = sel;
      preload(c, rc);
      if (st != c) preload(st, rs);
      model(rc, rs, (c == st), maxi, n, e);
      base = sel ? wq1.size() : wq0.size();
      @(negedge clk);
      drive_start(1'b1, c, st);
      @(posedge clk); #1;
      drive_start(1'b0, 0, 0);
      cyc = 1;
      chk({tag, ".busy_on"}, m_busy, 1);
      while (!m_done && cyc < 400) begin
         if (dbl && cyc == 4) drive_start(1'b1, c ^ 1, st ^ 1);
         else if (dbl && cyc == 5) drive_start(1'b0, 0, 0);
         @(posedge clk); #1;
         cyc++;
      end
      drive_start(1'b0, 0, 0);
      chk({tag, ".done_cycle"}, cyc, 3 * n + 3);
      chk({tag, ".err"}, m_err, e);
      chk({tag, ".iter"}, m_iter, n);
      chk({tag, ".busy_done"}, m_busy, 1);
      got_n = (sel ? wq1.size() : wq0.size()) - base;
      chk({tag, ".nwrites"}, got_n, n);
      for (int i = 0; i < n && i < got_n; i++)
         chk({tag, ".write"}, sel ? wq1[base + i] : wq0[base + i], c * 65536 + exp_q[i]);
      @(posedge clk); #1;
      chk({tag, ".busy_off"}, m_busy, 0);
      chk({tag, ".done_off"}, m_done, 0);
      chk({tag, ".a1_idle"}, m_a1, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, guard, c, st;
      bit sel;
      #12;
      for (int k = 0; k < 2; k++) begin
         cur = k[0];
         chk("rst.busy", m_busy, 0);
         chk("rst.rw", m_rw, 0);
         chk("rst.iter", m_iter, 0);
         chk("rst.a1a2", {m_a1, m_a2}, 0);
      end
      @(negedge clk);
      rst = 1'b1;

      run_case("r37", 0, 0, 1, 10, 1, 65535, 0);
      run_case("r38", 0, 2, 3, 7, 3, 65535, 0);
      run_case("r39", 0, 4, 5, 5, 0, 65535, 0);
      run_case("r40", 0, 6, 7, 0, 5, 65535, 0);
      run_case("same", 0, 8, 8, 6, 6, 65535, 0);
      run_case("dbl", 0, 0, 1, 10, 1, 65535, 1);
      run_case("r42", 1, 0, 1, 10, 1, 2, 0);

      // Reset asserted during the third WRITE of a 10/1 countdown.
      cur = 1'b0;
      preload(0, 10);
      preload(1, 1);
      @(negedge clk);
      drive_start(1'b1, 0, 1);
      @(posedge clk); #1;
      drive_start(1'b0, 0, 0);
      cnt = 0;
      guard = 0;
      while (cnt < 3 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
         if (m_rw) cnt++;
      end
      chk("mrst.reached", cnt, 3);
      rst = 1'b0;
      #1;
      chk("mrst.busy", m_busy, 0);
      chk("mrst.rw", m_rw, 0);
      chk("mrst.bus", {m_a1, m_a2, m_a3, m_wd}, 0);
      chk("mrst.flags", {m_done, m_err, m_iter}, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mrst.r0", regs0[0], 8);
      @(negedge clk);
      rst = 1'b1;

      run_case("post_rst", 0, 3, 4, 9, 4, 65535, 0);

      for (int i = 0; i < 10; i++) begin
         sel = (i % 3 == 2);
         c   = $urandom_range(0, 15);
         st  = ($urandom_range(0, 4) == 0) ? c : $urandom_range(0, 15);
         run_case("rnd", sel, c, st, $urandom_range(0, 40), $urandom_range(0, 6),
                  sel ? 2 : 65535, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
